// File: rtl/sva_stim_gen.sv
// Stimulus generator for SVA checker demos: pulses a, then b at a programmed
// offset, collects the checker verdict and keeps pass/fail/mismatch statistics.
module sva_stim_gen #(
    parameter int unsigned B_MIN        = 2,
    parameter int unsigned B_MAX        = 4,
    parameter int unsigned OFF_W        = 3,
    parameter int unsigned RESP_TIMEOUT = 16,
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             gclk,
    input  logic             grst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OFF_W-1:0] cmd_b_off,
    output logic             a_o,
    output logic             b_o,
    input  logic             succ_i,
    input  logic             fail_i,
    output logic             res_valid,
    output logic             res_pass_obs,
    output logic             res_match,
    output logic             res_timeout,
    output logic             res_multi,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] mismatch_cnt
);

    localparam int unsigned T_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam int unsigned G_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [T_W-1:0]   T_LAST    = T_W'((RESP_TIMEOUT > 0) ? RESP_TIMEOUT - 1 : 0);
    localparam logic [G_W-1:0]   G_LAST    = G_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [OFF_W-1:0] OFF_MIN   = OFF_W'(B_MIN);
    localparam logic [OFF_W-1:0] OFF_MAX   = OFF_W'(B_MAX);
    localparam bit               HAS_GUARD = (GUARD_CYCLES > 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_REPORT,
        S_GUARD
    } state_t;

    state_t           state;
    logic [OFF_W-1:0] off;
    logic [OFF_W-1:0] cnt;
    logic [T_W-1:0]   wcnt;
    logic [G_W-1:0]   gcnt;
    logic             exp_pass;
    logic             got;
    logic             obs;
    logic             multi;

    // Response bookkeeping including whatever arrives in the current cycle
    logic resp_c;
    logic got_c;
    logic obs_c;
    logic multi_c;
    logic report_c;

    assign resp_c   = succ_i | fail_i;
    assign got_c    = got | resp_c;
    assign obs_c    = got ? obs : succ_i;
    assign multi_c  = multi | (got & resp_c) | (succ_i & fail_i);
    assign report_c = ((state == S_DRIVE) && (cnt == OFF_MAX) && got_c) ||
                      ((state == S_WAIT) && (resp_c || (wcnt == T_LAST)));

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge gclk) begin
        if (grst) begin
            state        <= S_IDLE;
            cmd_ready    <= 1'b1;
            a_o          <= 1'b0;
            b_o          <= 1'b0;
            res_valid    <= 1'b0;
            res_pass_obs <= 1'b0;
            res_match    <= 1'b0;
            res_timeout  <= 1'b0;
            res_multi    <= 1'b0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            mismatch_cnt <= '0;
            off          <= '0;
            cnt          <= '0;
            wcnt         <= '0;
            gcnt         <= '0;
            exp_pass     <= 1'b0;
            got          <= 1'b0;
            obs          <= 1'b0;
            multi        <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    a_o <= 1'b0;
                    b_o <= 1'b0;
                    if (cmd_valid) begin
                        off       <= cmd_b_off;
                        exp_pass  <= (cmd_b_off >= OFF_MIN) && (cmd_b_off <= OFF_MAX);
                        cnt       <= '0;
                        got       <= 1'b0;
                        obs       <= 1'b0;
                        multi     <= 1'b0;
                        a_o       <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    got   <= got_c;
                    obs   <= obs_c;
                    multi <= multi_c;
                    a_o   <= 1'b0;
                    if (cnt == OFF_MAX) begin
                        b_o   <= 1'b0;
                        wcnt  <= '0;
                        state <= got_c ? S_REPORT : S_WAIT;
                    end else begin
                        cnt <= cnt + OFF_W'(1);
                        // off = 0 never matches since the next count is at least 1
                        b_o <= ((cnt + OFF_W'(1)) == off);
                    end
                end
                S_WAIT: begin
                    got   <= got_c;
                    obs   <= obs_c;
                    multi <= multi_c;
                    if (resp_c || (wcnt == T_LAST)) begin
                        state <= S_REPORT;
                    end else begin
                        wcnt <= wcnt + T_W'(1);
                    end
                end
                S_REPORT: begin
                    if (res_match && res_pass_obs) begin
                        pass_cnt <= sat_inc(pass_cnt);
                    end else if (res_match) begin
                        fail_cnt <= sat_inc(fail_cnt);
                    end else begin
                        mismatch_cnt <= sat_inc(mismatch_cnt);
                    end
                    gcnt <= '0;
                    if (HAS_GUARD) begin
                        state <= S_GUARD;
                    end else begin
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                S_GUARD: begin
                    if (gcnt == G_LAST) begin
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                    end else begin
                        gcnt <= gcnt + G_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Verdict is captured on the edge that enters REPORT
            if (report_c) begin
                res_valid    <= 1'b1;
                res_pass_obs <= obs_c;
                res_timeout  <= !got_c;
                res_multi    <= multi_c;
                res_match    <= got_c && !multi_c && (obs_c == exp_pass);
            end
        end
    end

endmodule
